// File: rtl/if_id_buffer.sv
// IF/ID decoupling queue: a small first-word fall-through FIFO that carries fetched
// instructions from IF to ID. IF is held via if_stallreq_o when the queue is full.
module if_id_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     id_stall_i,
    input  logic                     if_valid_i,
    input  logic [31:0]              if_pc_i,
    input  logic [31:0]              if_inst_i,
    input  logic                     if_in_delay_slot_i,
    output logic                     if_stallreq_o,
    output logic                     id_valid_o,
    output logic [31:0]              id_pc_o,
    output logic [31:0]              id_inst_o,
    output logic                     id_in_delay_slot_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    // Entry storage, deliberately left without reset
    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];
    logic        ds_mem   [DEPTH];

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Full/empty come from registered count only, so a pop never frees a slot for a
    // same-cycle push and an empty queue never bypasses input to output.
    always_comb begin
        full  = (count_q == FullCnt);
        empty = (count_q == '0);
        push  = if_valid_i & ~full & ~flush_i;
        pop   = ~empty & ~id_stall_i & ~flush_i;
    end

    // Next-state for pointers and occupancy; flush overrides push and pop
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PtrW'(1);
            if (pop)  head_d = head_q + PtrW'(1);
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Write the accepted entry at the tail
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]   <= if_pc_i;
            inst_mem[tail_q] <= if_inst_i;
            ds_mem[tail_q]   <= if_in_delay_slot_i;
        end
    end

    // Head entry drives ID directly; an empty queue presents a NOP
    always_comb begin
        id_valid_o         = ~empty;
        if_stallreq_o      = full;
        count_o            = count_q;
        id_pc_o            = '0;
        id_inst_o          = '0;
        id_in_delay_slot_o = 1'b0;
        if (!empty) begin
            id_pc_o            = pc_mem[head_q];
            id_inst_o          = inst_mem[head_q];
            id_in_delay_slot_o = ds_mem[head_q];
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer (DEPTH=4). Inputs change and outputs are sampled on
// the falling edge, half a period away from the rising edge that updates state.
module tb_if_id_buffer;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        id_stall_i;
    logic        if_valid_i;
    logic [31:0] if_pc_i;
    logic [31:0] if_inst_i;
    logic        if_in_delay_slot_i;
    logic        if_stallreq_o;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_in_delay_slot_o;
    logic [2:0]  count_o;

    int n_checks;
    int n_fail;

    if_id_buffer #(.DEPTH(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush_i            (flush_i),
        .id_stall_i         (id_stall_i),
        .if_valid_i         (if_valid_i),
        .if_pc_i            (if_pc_i),
        .if_inst_i          (if_inst_i),
        .if_in_delay_slot_i (if_in_delay_slot_i),
        .if_stallreq_o      (if_stallreq_o),
        .id_valid_o         (id_valid_o),
        .id_pc_o            (id_pc_o),
        .id_inst_o          (id_inst_o),
        .id_in_delay_slot_o (id_in_delay_slot_o),
        .count_o            (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush_i            = 1'b0;
        if_valid_i         = 1'b0;
        if_pc_i            = 32'h0;
        if_inst_i          = 32'h0;
        if_in_delay_slot_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        id_stall_i = 1'b0;
        step();
        step();
        n_checks++;
        if (count_o !== 3'd0) begin
            n_fail++; $display("FAIL reset_count got %0d want 0", count_o);
        end
        n_checks++;
        if (id_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got %b want 0", id_valid_o);
        end
        n_checks++;
        if (if_stallreq_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_stallreq got %b want 0", if_stallreq_o);
        end
        n_checks++;
        if (id_pc_o !== 32'h0 || id_inst_o !== 32'h0 || id_in_delay_slot_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data got pc=%h inst=%h ds=%b want 0/0/0",
                     id_pc_o, id_inst_o, id_in_delay_slot_o);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        id_stall_i = 1'b0;
        if_valid_i = 1'b1;
        if_pc_i    = 32'hBFC0_0000;
        if_inst_i  = 32'h2408_0001;
        n_checks++;
        if (id_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL single_no_bypass got valid=%b want 0", id_valid_o);
        end
        step();
        idle_inputs();
        n_checks++;
        if (id_valid_o !== 1'b1 || id_pc_o !== 32'hBFC0_0000 || id_inst_o !== 32'h2408_0001)
        begin
            n_fail++;
            $display("FAIL single_out got valid=%b pc=%h inst=%h want 1 bfc00000 24080001",
                     id_valid_o, id_pc_o, id_inst_o);
        end
        step();
        n_checks++;
        if (id_valid_o !== 1'b0 || count_o !== 3'd0) begin
            n_fail++;
            $display("FAIL single_drain got valid=%b count=%0d want 0 0", id_valid_o, count_o);
        end
    endtask

    task automatic test_fill_and_drain();
        logic [31:0] pcs [5];
        pcs = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
        id_stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if_valid_i = 1'b1;
            if_pc_i    = pcs[i];
            if_inst_i  = 32'hA000_0000 | pcs[i];
            step();
            if (i == 3) begin
                n_checks++;
                if (count_o !== 3'd4 || if_stallreq_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fill_full got count=%0d stallreq=%b want 4 1",
                             count_o, if_stallreq_o);
                end
            end
        end
        idle_inputs();
        n_checks++;
        if (count_o !== 3'd4 || id_pc_o !== 32'h100) begin
            n_fail++;
            $display("FAIL fill_drop got count=%0d head=%h want 4 100", count_o, id_pc_o);
        end
        id_stall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (id_valid_o !== 1'b1 || id_pc_o !== pcs[i] ||
                id_inst_o !== (32'hA000_0000 | pcs[i])) begin
                n_fail++;
                $display("FAIL drain_order[%0d] got valid=%b pc=%h inst=%h want pc=%h",
                         i, id_valid_o, id_pc_o, id_inst_o, pcs[i]);
            end
            step();
        end
        n_checks++;
        if (id_valid_o !== 1'b0 || id_pc_o !== 32'h0 || count_o !== 3'd0) begin
            n_fail++;
            $display("FAIL drain_empty got valid=%b pc=%h count=%0d want 0 0 0",
                     id_valid_o, id_pc_o, count_o);
        end
    endtask

    task automatic test_full_push_pop();
        id_stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_valid_i = 1'b1;
            if_pc_i    = 32'h300 + 32'(4 * i);
            step();
        end
        // Full: pop happens, push of 0x400 must be refused
        id_stall_i = 1'b0;
        if_pc_i    = 32'h400;
        step();
        idle_inputs();
        n_checks++;
        if (count_o !== 3'd3 || if_stallreq_o !== 1'b0 || id_pc_o !== 32'h304) begin
            n_fail++;
            $display("FAIL full_pushpop got count=%0d stallreq=%b head=%h want 3 0 304",
                     count_o, if_stallreq_o, id_pc_o);
        end
        step();
        step();
        n_checks++;
        if (id_pc_o !== 32'h30C || count_o !== 3'd1) begin
            n_fail++;
            $display("FAIL full_pushpop_tail got head=%h count=%0d want 30c 1 (400 absent)",
                     id_pc_o, count_o);
        end
        step();
    endtask

    task automatic test_flush();
        id_stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if_valid_i = 1'b1;
            if_pc_i    = 32'h500 + 32'(4 * i);
            if_inst_i  = 32'h1111_0000 + 32'(i);
            step();
        end
        n_checks++;
        if (count_o !== 3'd2) begin
            n_fail++; $display("FAIL flush_pre got count=%0d want 2", count_o);
        end
        flush_i    = 1'b1;
        id_stall_i = 1'b0;
        if_pc_i    = 32'h508;
        if_inst_i  = 32'h2222_2222;
        step();
        idle_inputs();
        n_checks++;
        if (count_o !== 3'd0 || id_valid_o !== 1'b0 || id_inst_o !== 32'h0) begin
            n_fail++;
            $display("FAIL flush_clear got count=%0d valid=%b inst=%h want 0 0 0",
                     count_o, id_valid_o, id_inst_o);
        end
        step();
        n_checks++;
        if (count_o !== 3'd0 || id_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_push_absent got count=%0d valid=%b want 0 0",
                     count_o, id_valid_o);
        end
    endtask

    task automatic test_stream();
        id_stall_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if_valid_i         = 1'b1;
            if_pc_i            = 32'h200 + 32'(4 * k);
            if_inst_i          = 32'h3000_0000 + 32'(k);
            if_in_delay_slot_i = (k == 3);
            step();
            n_checks++;
            if (id_valid_o !== 1'b1 || count_o !== 3'd1 ||
                id_pc_o !== 32'h200 + 32'(4 * k) ||
                id_inst_o !== 32'h3000_0000 + 32'(k) ||
                id_in_delay_slot_o !== (k == 3)) begin
                n_fail++;
                $display("FAIL stream[%0d] got valid=%b count=%0d pc=%h inst=%h ds=%b",
                         k, id_valid_o, count_o, id_pc_o, id_inst_o, id_in_delay_slot_o);
            end
        end
        idle_inputs();
        step();
        n_checks++;
        if (id_valid_o !== 1'b0 || id_in_delay_slot_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end got valid=%b ds=%b want 0 0",
                     id_valid_o, id_in_delay_slot_o);
        end
    endtask

    task automatic test_async_reset();
        id_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_valid_i = 1'b1;
            if_pc_i    = 32'h700 + 32'(4 * i);
            step();
        end
        idle_inputs();
        n_checks++;
        if (count_o !== 3'd3) begin
            n_fail++; $display("FAIL async_pre got count=%0d want 3", count_o);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (id_valid_o !== 1'b0 || count_o !== 3'd0 || id_pc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset got valid=%b count=%0d pc=%h want 0 0 0",
                     id_valid_o, count_o, id_pc_o);
        end
        step();
        rst_n      = 1'b1;
        id_stall_i = 1'b0;
        step();
        if_valid_i = 1'b1;
        if_pc_i    = 32'h600;
        step();
        idle_inputs();
        n_checks++;
        if (id_valid_o !== 1'b1 || id_pc_o !== 32'h600 || count_o !== 3'd1) begin
            n_fail++;
            $display("FAIL async_first_push got valid=%b pc=%h count=%0d want 1 600 1",
                     id_valid_o, id_pc_o, count_o);
        end
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        id_stall_i = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_fill_and_drain();
        test_full_push_pop();
        test_flush();
        test_stream();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
